direction_keypad: RTL and testbench



---
 rtl/direction_keypad_pkg.sv | 34 +++
 rtl/direction_keypad_button_debounce.sv | 53 +++++
 rtl/direction_keypad.sv | 64 ++++++
 tb/tb_direction_keypad.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/direction_keypad_pkg.sv
// rtl/direction_keypad_pkg.sv - shared direction codes, button indices and press priority
package direction_keypad_pkg;

    localparam int NUM_DIRS  = 4;
    localparam int NUM_CHANS = 5;

    // Bit positions of the direction buttons on btn_raw / held.
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    // The start button rides on the debounce channel after the directions.
    localparam int CHAN_START = 4;

    // One-hot movement codes understood by the snake movement logic.
    typedef enum logic [3:0] {
        DIR_NONE  = 4'd0,
        DIR_UP    = 4'd1,
        DIR_DOWN  = 4'd2,
        DIR_LEFT  = 4'd4,
        DIR_RIGHT = 4'd8
    } dir_code_t;

    // Fixed priority UP > DOWN > LEFT > RIGHT. Losing presses are dropped.
    function automatic dir_code_t prio_select(input logic [NUM_DIRS-1:0] rises);
        if (rises[BTN_UP])    return DIR_UP;
        if (rises[BTN_DOWN])  return DIR_DOWN;
        if (rises[BTN_LEFT])  return DIR_LEFT;
        if (rises[BTN_RIGHT]) return DIR_RIGHT;
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/direction_keypad_button_debounce.sv
// rtl/direction_keypad_button_debounce.sv - synchroniser, debounce counter and press detect for one button
//   clk   : system clock
//   reset : asynchronous active-low reset
//   raw   : asynchronous active-high button input
//   level : debounced button level (registered)
//   rise  : high during the cycle whose clock edge flips level 0->1
module button_debounce
    import direction_keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    // flip and rise depend only on flops, so the consumer can register the
    // press on the same edge that updates level without any input-to-output path.
    assign flip = (s2 != level) && (cnt == CNT_LAST);
    assign rise = flip && !level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // Any agreement between s2 and level restarts the qualification window.
            if (s2 == level) begin
                cnt <= '0;
            end else if (flip) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/direction_keypad.sv
// rtl/direction_keypad.sv - debounced direction/start keypad front end for the snake game
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   btn_raw   : raw direction buttons [0]=up [1]=down [2]=left [3]=right
//   start_raw : raw start button
//   movement  : one-cycle one-hot direction code per press, 0 when idle
//   start     : one-cycle pulse per debounced start press
//   held      : debounced level of each direction button
//   last_dir  : most recent non-zero movement code
module direction_keypad
    import direction_keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    input  logic       start_raw,
    output logic [3:0] movement,
    output logic       start,
    output logic [3:0] held,
    output logic [3:0] last_dir
);

    logic [NUM_CHANS-1:0] raw_all;
    logic [NUM_CHANS-1:0] level;
    logic [NUM_CHANS-1:0] rise;
    dir_code_t            next_move;

    assign raw_all = {start_raw, btn_raw};

    for (genvar i = 0; i < NUM_CHANS; i++) begin : g_chan
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_all[i]),
            .level (level[i]),
            .rise  (rise[i])
        );
    end

    assign held      = level[NUM_DIRS-1:0];
    assign next_move = prio_select(rise[NUM_DIRS-1:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            movement <= DIR_NONE;
            start    <= 1'b0;
            last_dir <= DIR_NONE;
        end else begin
            movement <= next_move;
            // A start press is only taken from the released state.
            start    <= rise[CHAN_START] && !level[CHAN_START];
            if (next_move != DIR_NONE) begin
                last_dir <= next_move;
            end
        end
    end

endmodule

// File: tb/tb_direction_keypad.sv
// tb/tb_direction_keypad.sv - randomized and directed checks of direction_keypad against a window model
module tb_direction_keypad;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] btn_raw = 4'd0;
    logic       start_raw = 1'b0;
    logic [3:0] movement;
    logic       start;
    logic [3:0] held;
    logic [3:0] last_dir;

    direction_keypad #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .start_raw (start_raw),
        .movement  (movement),
        .start     (start),
        .held      (held),
        .last_dir  (last_dir)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: a level flips once every one of the last DB synchronised
    // samples (all taken after the previous flip) disagrees with it.
    logic [4:0] m_s1, m_s2, m_db;
    logic [4:0] hist[$];
    int         last_flip[5];
    logic [3:0] exp_move, exp_held, exp_last;
    logic       exp_start;

    task automatic model_reset();
        m_s1 = '0;
        m_s2 = '0;
        m_db = '0;
        hist.delete();
        for (int c = 0; c < 5; c++) last_flip[c] = -1;
        exp_move  = '0;
        exp_start = 1'b0;
        exp_held  = '0;
        exp_last  = '0;
    endtask

    task automatic model_step();
        logic [4:0] rises;
        logic [4:0] sample;
        int         k;
        bit         ok;
        rises = '0;
        hist.push_back(m_s2);
        k = hist.size() - 1;
        for (int c = 0; c < 5; c++) begin
            if (k - last_flip[c] >= DB) begin
                ok = 1'b1;
                for (int j = k - DB + 1; j <= k; j++) begin
                    sample = hist[j];
                    if (sample[c] == m_db[c]) ok = 1'b0;
                end
                if (ok) begin
                    m_db[c]      = ~m_db[c];
                    last_flip[c] = k;
                    rises[c]     = m_db[c];
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = {start_raw, btn_raw};
        exp_move = '0;
        for (int c = 3; c >= 0; c--) if (rises[c]) exp_move = 4'(1 << c);
        exp_start = rises[4];
        if (exp_move != 0) exp_last = exp_move;
        exp_held = m_db[3:0];
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        else model_reset();
        @(negedge clk);
        check("movement", movement, exp_move);
        check("start", start, exp_start);
        check("held", held, exp_held);
        check("last_dir", last_dir, exp_last);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_count(input int n, input logic [3:0] code, output int n_code,
                             output int n_other, output int first_move, output int first_start);
        n_code = 0;
        n_other = 0;
        first_move = -1;
        first_start = -1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (movement == code) begin
                n_code++;
                if (first_move < 0) first_move = i;
            end else if (movement != 0) begin
                n_other++;
            end
            if (start && first_start < 0) first_start = i;
        end
    endtask

    int nc, no, fm, fs;

    initial begin
        model_reset();

        // Reset held low with inputs toggling: everything stays quiet.
        for (int i = 0; i < 20; i++) begin
            btn_raw   = 4'($urandom_range(0, 15));
            start_raw = 1'($urandom_range(0, 1));
            tick();
        end
        btn_raw = '0;
        start_raw = 1'b0;
        reset = 1'b1;
        idle(10);

        // Single UP press held: one pulse after DB+1 edges, no repeat.
        btn_raw = 4'b0001;
        run_count(30, 4'd1, nc, no, fm, fs);
        check("up_count", nc, 1);
        check("up_first", fm, DB + 1);
        check("up_held", held, 4'b0001);
        check("up_last", last_dir, 4'd1);
        btn_raw = '0;
        idle(12);

        // Short RIGHT glitch: filtered.
        btn_raw = 4'b1000;
        idle(3);
        btn_raw = '0;
        run_count(12, 4'd8, nc, no, fm, fs);
        check("glitch_count", nc + no, 0);

        // LEFT chattering then stable high.
        for (int p = 0; p < 6; p++) begin
            btn_raw = (p % 2 == 0) ? 4'b0100 : 4'b0000;
            tick();
            if (movement != 0) check("chatter_quiet", movement, 0);
            tick();
            if (movement != 0) check("chatter_quiet", movement, 0);
        end
        btn_raw = 4'b0100;
        run_count(20, 4'd4, nc, no, fm, fs);
        check("chatter_count", nc, 1);
        check("chatter_first", fm, DB + 1);
        btn_raw = '0;
        idle(12);

        // DOWN and RIGHT together: DOWN wins, RIGHT is discarded.
        btn_raw = 4'b1010;
        run_count(20, 4'd2, nc, no, fm, fs);
        check("prio_count", nc, 1);
        check("prio_other", no, 0);
        check("prio_last", last_dir, 4'd2);
        btn_raw = 4'b0010;
        idle(10);
        btn_raw = 4'b1010;
        run_count(20, 4'd8, nc, no, fm, fs);
        check("repress_right", nc, 1);
        btn_raw = '0;
        idle(12);

        // Start and UP together pulse on the same edge.
        btn_raw = 4'b0001;
        start_raw = 1'b1;
        run_count(15, 4'd1, nc, no, fm, fs);
        check("both_move_first", fm, DB + 1);
        check("both_start_first", fs, DB + 1);
        btn_raw = '0;
        start_raw = 1'b0;
        idle(12);

        // Async reset mid-count with UP held, then normal latency after release.
        btn_raw = 4'b0001;
        idle(3);
        #2 reset = 1'b0;
        #1;
        check("areset_last", last_dir, 0);
        check("areset_move", movement, 0);
        check("areset_held", held, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        run_count(15, 4'd1, nc, no, fm, fs);
        check("post_reset_count", nc, 1);
        check("post_reset_first", fm, DB + 1);
        btn_raw = '0;
        idle(12);

        // Random segments with occasional reset pulses.
        for (int s = 0; s < 400; s++) begin
            btn_raw   = 4'($urandom_range(0, 15));
            start_raw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            idle($urandom_range(1, 10));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
